// File: rtl/uart_core_v2.sv
// Full-duplex UART: runtime divisor, parity mode and stop-bit count, valid/ready on both sides.
// Optional internal loopback is enabled by defining UART_LOOPBACK_EN.
module uart_core_v2 #(
   parameter int G_WORD_WIDTH = 8,
   parameter int G_OVERSAMPLE = 16,
   parameter int G_DIV_WIDTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [G_DIV_WIDTH-1:0]  i_div,
   input  logic [1:0]              i_parity_mode,
   input  logic                    i_stop2,
   input  logic                    i_tx_valid,
   output logic                    o_tx_ready,
   input  logic [G_WORD_WIDTH-1:0] i_tx_data,
   output logic                    o_tx,
   output logic                    o_tx_busy,
   input  logic                    i_rx,
   output logic                    o_rx_valid,
   input  logic                    i_rx_ready,
   output logic [G_WORD_WIDTH-1:0] o_rx_data,
   output logic                    o_rx_parity_err,
   output logic                    o_rx_frame_err,
   output logic                    o_rx_overrun
`ifdef UART_LOOPBACK_EN
   ,
   input  logic                    i_loopback
`endif
);

   localparam int C_OS_W  = $clog2(G_OVERSAMPLE);
   localparam int C_BIT_W = $clog2(G_WORD_WIDTH);
   localparam logic [C_OS_W-1:0]  C_OS_LAST  = C_OS_W'(G_OVERSAMPLE - 1);
   localparam logic [C_OS_W-1:0]  C_OS_HALF  = C_OS_W'(G_OVERSAMPLE / 2 - 1);
   localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(G_WORD_WIDTH - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

   // ---------------------------------------------------------------- TX
   tx_state_t                tx_state, tx_next;
   logic [G_DIV_WIDTH-1:0]   tx_div_q, tx_pre;
   logic [C_OS_W-1:0]        tx_os;
   logic [C_BIT_W-1:0]       tx_bit;
   logic [G_WORD_WIDTH-1:0]  tx_shift;
   logic                     tx_par, tx_par_en, tx_stop2_q;
   logic                     tx_tick, tx_bit_end, tx_line;

   assign tx_tick    = (tx_pre == tx_div_q);
   assign tx_bit_end = tx_tick && (tx_os == C_OS_LAST);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:   if (i_tx_valid) tx_next = TX_START;
         TX_START:  if (tx_bit_end) tx_next = TX_DATA;
         TX_DATA:   if (tx_bit_end && tx_bit == C_BIT_LAST) tx_next = tx_par_en ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
         TX_STOP:   if (tx_bit_end && tx_bit == {{(C_BIT_W-1){1'b0}}, tx_stop2_q}) tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (!i_rst_n) begin
         tx_state   <= TX_IDLE;
         tx_div_q   <= '0;
         tx_pre     <= '0;
         tx_os      <= '0;
         tx_bit     <= '0;
         tx_shift   <= '0;
         tx_par     <= 1'b0;
         tx_par_en  <= 1'b0;
         tx_stop2_q <= 1'b0;
      end else begin
         tx_state <= tx_next;
         if (tx_state == TX_IDLE) begin
            tx_pre <= '0;
            tx_os  <= '0;
            tx_bit <= '0;
            if (i_tx_valid) begin
               tx_shift   <= i_tx_data;
               tx_div_q   <= i_div;
               tx_par_en  <= i_parity_mode[0] ^ i_parity_mode[1];
               tx_par     <= (^i_tx_data) ^ (i_parity_mode == 2'b10);
               tx_stop2_q <= i_stop2;
            end
         end else begin
            tx_pre <= tx_tick ? '0 : tx_pre + 1'b1;
            if (tx_tick) tx_os <= (tx_os == C_OS_LAST) ? '0 : tx_os + 1'b1;
            if (tx_bit_end) begin
               if (tx_state == TX_DATA) begin
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= (tx_bit == C_BIT_LAST) ? '0 : tx_bit + 1'b1;
               end else if (tx_state == TX_STOP) begin
                  tx_bit <= tx_bit + 1'b1;
               end
            end
         end
      end
   end

   // Line level is decoded from state, so reset drives it high without waiting for a clock.
   always_comb begin
      tx_line = 1'b1;
      case (tx_state)
         TX_START:  tx_line = 1'b0;
         TX_DATA:   tx_line = tx_shift[0];
         TX_PARITY: tx_line = tx_par;
         default:   tx_line = 1'b1;
      endcase
   end

   assign o_tx_ready = (tx_state == TX_IDLE);
   assign o_tx_busy  = (tx_state != TX_IDLE);

   // ---------------------------------------------------------------- RX
   rx_state_t                rx_state, rx_next;
   logic                     rx_meta, rx_sync, rx_prev, rx_in, rx_fall;
   logic [G_DIV_WIDTH-1:0]   rx_div_q, rx_pre;
   logic [C_OS_W-1:0]        rx_os;
   logic [C_BIT_W-1:0]       rx_bit;
   logic [G_WORD_WIDTH-1:0]  rx_shift;
   logic                     rx_par_en, rx_odd_q, rx_par_err_q;
   logic                     rx_tick, rx_sample, rx_done;

`ifdef UART_LOOPBACK_EN
   assign rx_in = i_loopback ? tx_line : rx_sync;
   assign o_tx  = i_loopback ? 1'b1 : tx_line;
`else
   assign rx_in = rx_sync;
   assign o_tx  = tx_line;
`endif

   assign rx_fall   = rx_prev && !rx_in;
   assign rx_tick   = (rx_pre == rx_div_q);
   assign rx_sample = rx_tick && (rx_os == ((rx_state == RX_START) ? C_OS_HALF : C_OS_LAST));
   assign rx_done   = (rx_state == RX_STOP) && rx_sample;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:   if (rx_fall) rx_next = RX_START;
         RX_START:  if (rx_sample) rx_next = rx_in ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_sample && rx_bit == C_BIT_LAST) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_sample) rx_next = RX_STOP;
         RX_STOP:   if (rx_sample) rx_next = rx_in ? RX_IDLE : RX_BREAK;
         RX_BREAK:  if (rx_in) rx_next = RX_IDLE;
         default:   rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_state        <= RX_IDLE;
         rx_meta         <= 1'b1;
         rx_sync         <= 1'b1;
         rx_prev         <= 1'b1;
         rx_div_q        <= '0;
         rx_pre          <= '0;
         rx_os           <= '0;
         rx_bit          <= '0;
         rx_shift        <= '0;
         rx_par_en       <= 1'b0;
         rx_odd_q        <= 1'b0;
         rx_par_err_q    <= 1'b0;
         o_rx_valid      <= 1'b0;
         o_rx_data       <= '0;
         o_rx_parity_err <= 1'b0;
         o_rx_frame_err  <= 1'b0;
         o_rx_overrun    <= 1'b0;
      end else begin
         rx_meta      <= i_rx;
         rx_sync      <= rx_meta;
         rx_prev      <= rx_in;
         rx_state     <= rx_next;
         o_rx_overrun <= 1'b0;

         if (rx_state == RX_IDLE || rx_state == RX_BREAK) begin
            rx_pre <= '0;
            rx_os  <= '0;
            rx_bit <= '0;
            if (rx_state == RX_IDLE && rx_fall) begin
               rx_div_q     <= i_div;
               rx_par_en    <= i_parity_mode[0] ^ i_parity_mode[1];
               rx_odd_q     <= (i_parity_mode == 2'b10);
               rx_par_err_q <= 1'b0;
            end
         end else begin
            rx_pre <= rx_tick ? '0 : rx_pre + 1'b1;
            if (rx_tick) rx_os <= (rx_sample || rx_os == C_OS_LAST) ? '0 : rx_os + 1'b1;
            if (rx_sample && rx_state == RX_DATA) begin
               rx_shift <= {rx_in, rx_shift[G_WORD_WIDTH-1:1]};
               rx_bit   <= (rx_bit == C_BIT_LAST) ? '0 : rx_bit + 1'b1;
            end
            if (rx_sample && rx_state == RX_PARITY)
               rx_par_err_q <= (^rx_shift) ^ rx_in ^ rx_odd_q;
         end

         // A word completing while the old one is still unaccepted is dropped.
         if (rx_done) begin
            if (!o_rx_valid || i_rx_ready) begin
               o_rx_valid      <= 1'b1;
               o_rx_data       <= rx_shift;
               o_rx_parity_err <= rx_par_err_q;
               o_rx_frame_err  <= !rx_in;
            end else begin
               o_rx_overrun <= 1'b1;
            end
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_core_v2.sv
// Self-checking bench for uart_core_v2: frame-level reference model for TX, RX, loopback, errors, reset.
module tb_uart_core_v2;

   localparam int W  = 8;
   localparam int OS = 16;
   localparam int DW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [DW-1:0] i_div = '0;
   logic [1:0]    i_parity_mode = 2'b00;
   logic          i_stop2 = 1'b0;
   logic          i_tx_valid = 1'b0;
   logic          o_tx_ready;
   logic [W-1:0]  i_tx_data = '0;
   logic          o_tx, o_tx_busy;
   logic          rx_drv = 1'b1;
   logic          use_wire = 1'b0;
   logic          rx_pin;
   logic          o_rx_valid;
   logic          i_rx_ready = 1'b1;
   logic [W-1:0]  o_rx_data;
   logic          o_rx_parity_err, o_rx_frame_err, o_rx_overrun;
`ifdef UART_LOOPBACK_EN
   logic          loopback = 1'b0;
`endif

   assign rx_pin = use_wire ? o_tx : rx_drv;

   uart_core_v2 #(.G_WORD_WIDTH(W), .G_OVERSAMPLE(OS), .G_DIV_WIDTH(DW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_div(i_div), .i_parity_mode(i_parity_mode),
      .i_stop2(i_stop2), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
      .i_tx_data(i_tx_data), .o_tx(o_tx), .o_tx_busy(o_tx_busy), .i_rx(rx_pin),
      .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data),
      .o_rx_parity_err(o_rx_parity_err), .o_rx_frame_err(o_rx_frame_err),
      .o_rx_overrun(o_rx_overrun)
`ifdef UART_LOOPBACK_EN
      , .i_loopback(loopback)
`endif
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ovr_cnt = 0;
   logic [W+1:0] rxq[$];   // {parity_err, frame_err, data} per accepted word
   logic fbits[$];         // reference serial frame, one entry per bit

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_rx_valid && i_rx_ready) rxq.push_back({o_rx_parity_err, o_rx_frame_err, o_rx_data});
      if (o_rx_overrun) ovr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   // Frame from the line rules: start, LSB-first data, optional parity, stop bit(s).
   task automatic make_frame(input logic [W-1:0] d, input logic [1:0] mode, input logic two_stop,
                             input logic flip, input logic stopv);
      fbits.delete();
      fbits.push_back(1'b0);
      for (int i = 0; i < W; i++) fbits.push_back(d[i]);
      if (mode == 2'b01 || mode == 2'b10) fbits.push_back(((^d) ^ (mode == 2'b10)) ^ flip);
      fbits.push_back(stopv);
      if (two_stop) fbits.push_back(1'b1);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_tx_ready && n < 5000);
      check(tag, o_tx_ready, 1);
   endtask

   task automatic tx_frame(input logic [W-1:0] d, input int div, input logic [1:0] mode,
                           input logic two_stop);
      int bitclk, c, bad, idx;
      tick();
      i_div = DW'(div); i_parity_mode = mode; i_stop2 = two_stop;
      i_tx_data = d; i_tx_valid = 1'b1;
      wait_ready("tx_idle_ready");
      tick();
      i_tx_valid = 1'b0;
      // Scramble the configuration mid-frame: it must have been captured at accept.
      i_div = DW'(div + 5); i_parity_mode = ~mode; i_stop2 = ~two_stop; i_tx_data = ~d;
      make_frame(d, mode, two_stop, 1'b0, 1'b1);
      bitclk = (div + 1) * OS;
      c = 0; bad = 0;
      while (c < 20000) begin
         @(negedge i_clk);
         if (!o_tx_busy) break;
         idx = c / bitclk;
         if (idx >= fbits.size() || o_tx !== fbits[idx]) bad++;
         c++;
      end
      check("tx_bits", bad, 0);
      check("tx_len", c, fbits.size() * bitclk);
      check("tx_ready_after", o_tx_ready, 1);
   endtask

   task automatic rx_frame(input logic [W-1:0] d, input int div, input logic [1:0] mode,
                           input logic flip, input logic stopv);
      int bitclk;
      make_frame(d, mode, 1'b0, flip, stopv);
      bitclk = (div + 1) * OS;
      tick();
      i_div = DW'(div); i_parity_mode = mode;
      foreach (fbits[i]) begin
         rx_drv = fbits[i];
         repeat (bitclk) tick();
      end
      if (!stopv) repeat (3 * bitclk) tick();
      rx_drv = 1'b1;
      repeat (2 * bitclk) tick();
   endtask

   task automatic expect_rx(input string tag, input logic [W-1:0] d, input logic perr, input logic ferr);
      logic [W+1:0] got;
      check({tag, "_count"}, rxq.size(), 1);
      got = (rxq.size() > 0) ? rxq.pop_front() : '1;
      check({tag, "_word"}, got, {perr, ferr, d});
      rxq.delete();
   endtask

   initial begin
      logic [W-1:0] d;
      logic [1:0]   m;
      logic         f;
      int           dv, t0, t1, n;

      repeat (3) @(negedge i_clk);
      check("rst_tx", o_tx, 1);
      check("rst_ready", o_tx_ready, 1);
      check("rst_busy", o_tx_busy, 0);
      check("rst_rx_valid", o_rx_valid, 0);
      check("rst_rx_data", o_rx_data, 0);
      check("rst_flags", {o_rx_parity_err, o_rx_frame_err, o_rx_overrun}, 0);
      tick();
      i_rst_n = 1'b1;
      repeat (4) tick();

      tx_frame(8'hA5, 0, 2'b01, 1'b0);
      tx_frame(8'h00, 3, 2'b10, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tx_frame(W'($urandom), int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
      end

      // Back-to-back frames looped from o_tx to i_rx.
      rxq.delete();
      tick();
      use_wire = 1'b1; i_rx_ready = 1'b1;
      i_div = '0; i_parity_mode = 2'b01; i_stop2 = 1'b0;
      i_tx_data = 8'hA5; i_tx_valid = 1'b1;
      wait_ready("b2b_first_ready");
      tick();
      t0 = cyc;
      i_tx_data = 8'h3C;
      wait_ready("b2b_second_ready");
      tick();
      t1 = cyc;
      i_tx_valid = 1'b0;
      make_frame(8'hA5, 2'b01, 1'b0, 1'b0, 1'b1);
      check("b2b_gap", t1 - t0, fbits.size() * OS + 1);
      n = 0;
      while (rxq.size() < 2 && n < 1000) begin
         @(negedge i_clk);
         n++;
      end
      check("lb_count", rxq.size(), 2);
      check("lb_word0", (rxq.size() > 0) ? rxq.pop_front() : '1, {2'b00, 8'hA5});
      check("lb_word1", (rxq.size() > 0) ? rxq.pop_front() : '1, {2'b00, 8'h3C});
      repeat (40) tick();
      use_wire = 1'b0;
      rxq.delete();

      // Parity and framing errors, then break recovery.
      rx_frame(8'h5A, 0, 2'b01, 1'b1, 1'b1);
      expect_rx("rx_par_err", 8'h5A, 1'b1, 1'b0);
      rx_frame(8'h5A, 0, 2'b01, 1'b0, 1'b0);
      expect_rx("rx_frame_err", 8'h5A, 1'b0, 1'b1);
      rx_frame(8'hC3, 1, 2'b10, 1'b0, 1'b1);
      expect_rx("rx_after_break", 8'hC3, 1'b0, 1'b0);

      for (int k = 0; k < 4; k++) begin
         d  = W'($urandom);
         m  = 2'($urandom_range(0, 3));
         f  = 1'($urandom_range(0, 1));
         dv = int'($urandom_range(0, 2));
         rx_frame(d, dv, m, f, 1'b1);
         expect_rx("rx_rand", d, f && (m == 2'b01 || m == 2'b10), 1'b0);
      end

      // False start: low for 4 ticks only.
      tick();
      i_div = '0;
      rx_drv = 1'b0;
      repeat (4) tick();
      rx_drv = 1'b1;
      repeat (64) tick();
      @(negedge i_clk);
      check("false_start_q", rxq.size(), 0);
      check("false_start_valid", o_rx_valid, 0);

      // Overrun: two frames with the consumer stalled.
      tick();
      i_rx_ready = 1'b0;
      ovr_cnt = 0;
      rx_frame(8'h11, 0, 2'b00, 1'b0, 1'b1);
      rx_frame(8'h22, 0, 2'b00, 1'b0, 1'b1);
      @(negedge i_clk);
      check("ovr_pulses", ovr_cnt, 1);
      check("ovr_valid", o_rx_valid, 1);
      check("ovr_data", o_rx_data, 8'h11);
      tick();
      i_rx_ready = 1'b1;
      repeat (3) tick();
      expect_rx("ovr_held", 8'h11, 1'b0, 1'b0);

`ifdef UART_LOOPBACK_EN
      tick();
      loopback = 1'b1;
      i_div = '0; i_parity_mode = 2'b01; i_stop2 = 1'b0;
      i_tx_data = 8'h81; i_tx_valid = 1'b1;
      wait_ready("loop_ready");
      tick();
      i_tx_valid = 1'b0;
      repeat (40) tick();
      @(negedge i_clk);
      check("loop_tx_high", o_tx, 1);
      repeat (300) tick();
      expect_rx("loop_rx", 8'h81, 1'b0, 1'b0);
      loopback = 1'b0;
      repeat (4) tick();
`endif

      // Reset in the middle of a data bit.
      tick();
      i_div = '0; i_parity_mode = 2'b00; i_stop2 = 1'b0;
      i_tx_data = 8'h00; i_tx_valid = 1'b1;
      wait_ready("rst_mid_ready");
      tick();
      i_tx_valid = 1'b0;
      repeat (40) @(negedge i_clk);
      check("rst_mid_pre", o_tx, 0);
      #1 i_rst_n = 1'b0;
      #1;
      check("rst_mid_tx", o_tx, 1);
      check("rst_mid_ready", o_tx_ready, 1);
      check("rst_mid_busy", o_tx_busy, 0);
      repeat (2) tick();
      i_rst_n = 1'b1;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
